mini_cpu_param: RTL and testbench
=================================

Name: mini_cpu_param

Overview:
Parametrised successor to the board-level multicycle mini CPU, for the same switch/pushbutton front panel. It contains its own register file and ALU, so the whole CPU is one block. Adds the following, all generalised over data width and register count:
- synchronous reset
- one-cycle-per-state sequencing
- a done strobe
- sign-magnitude immediates
- optional status flags

Parameters:
- DATA_W, 16, register/result width (≥8)
- ADDR_W, 4, register address width; register file depth = 2**ADDR_W
- IMM_W, 7, immediate field width. MSB is the sign; the low IMM_W-1 bits are the magnitude. Must satisfy IMM_W-1 ≥ ADDR_W and IMM_W ≤ DATA_W.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- opcode  in  3  instruction opcode switches
- addr1  in  ADDR_W  destination register (source for DISPLAY)
- addr2  in  ADDR_W  first source register
- addr3_imm  in  IMM_W  shared switches: addr3 = addr3_imm[IMM_W-1 -: ADDR_W]; imm = whole field
- ligar  in  1  power pushbutton, active-low
- enviar  in  1  submit pushbutton, active-low
- result  out  DATA_W  last shown value
- on  out  1  high whenever state ≠ OFF
- estado  out  3  current state code
- done  out  1  one-cycle pulse on instruction completion

Behaviour:
- Reset (sync, highest priority):
  - state=OFF, result=0, done=0
  - all registers 0; button-pressed flags 0; latched instruction fields 0
- State codes: OFF=000, FETCH=001, DECODE=010, READ=011, CALC=100, STORE=110, SHOW=111. Code 101 is unused; if reached, go to OFF.
- estado is driven directly from the state register.
- Button edge rule (both buttons): a cycle with the button low sets its pressed flag. A cycle with the button high and the flag set is a release event; the flag clears.
- ligar release event:
  - OFF→FETCH; any other state→OFF.
  - Overrides every other transition in the same cycle.
  - Going OFF aborts the instruction in flight: no register write, result unchanged, done=0.
  - Register contents survive OFF.
- enviar pressed flag is tracked only in FETCH and is forced to 0 in every other state. Presses during execution are therefore discarded.
- FETCH, on an enviar release at cycle t:
  - latch opcode, addr1, addr2, addr3_imm
  - DECODE at t+1, READ t+2, CALC t+3, STORE t+4, SHOW t+5, FETCH t+6
- READ: capture R[addr2] and R[addr3] into operand registers.
- CALC: compute alu_q (DATA_W bits), registered.
- immx: sign-magnitude imm converted to DATA_W two's complement. Negative zero = 0.
- Opcodes (all arithmetic wraps modulo 2**DATA_W):
  - 000 LOAD: R[addr1] ← immx
  - 001 ADD: R[addr1] ← R[addr2]+R[addr3]
  - 010 ADDI: R[addr1] ← R[addr2]+immx
  - 011 SUB: R[addr1] ← R[addr2]−R[addr3]
  - 100 SUBI: R[addr1] ← R[addr2]−immx
  - 101 MUL: R[addr1] ← low DATA_W bits of R[addr2]*R[addr3]
  - 110 CLEAR: all registers ← 0 and alu_q=0, both at the end of STORE
  - 111 DISPLAY: alu_q=R[addr1]; no register write
- STORE: the write occurs at the clock edge ending STORE.
- SHOW: at the edge ending SHOW, result←alu_q and done←1 (done is visible in the first FETCH cycle, for exactly one cycle).
- addr1=addr2=addr3 is legal; sources read the pre-write values.
- A LOAD followed immediately by an ADD reads the new value, since the write completes before the next READ.

Optional Feature:
Macro MINI_CPU_FLAGS_EN.
- Defined: adds output ports zero, neg, ovf (1 bit each), updated together with result in SHOW.
  - zero = (alu_q==0)
  - neg = alu_q[DATA_W-1]
  - ovf = signed overflow for ADD/ADDI/SUB/SUBI, or full signed product not representable in DATA_W for MUL; 0 for LOAD/CLEAR/DISPLAY
  - All three reset to 0 and are held while OFF.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then ligar pulse low 2 cycles → on=1, estado=001 one cycle after release; result=0, done=0.
- LOAD R1 with imm 7'b0000101, then DISPLAY R1 → result=5, done pulses exactly 6 cycles after each enviar release.
- LOAD R2=imm 0x45 (−5), ADD R3=R1+R2, then SUBI R4=R3−3 → result −3 (0xFFFD for DATA_W=16); with flags: neg=1, ovf=0.
- R5=0x7FFF via ADDI chain, ADD R6=R5+R5 → result=0xFFFE, ovf=1; MUL of 0x0100 by 0x0100 → result=0x0000, zero=1, ovf=1.
- ligar release while estado=100 (CALC) → estado=000 next cycle, target register unchanged, no done. Re-power and DISPLAY → old value.
- enviar pressed during DECODE → ignored. ligar and enviar released in the same FETCH cycle → OFF, no execution. CLEAR then DISPLAY R1 → 0. Sync reset asserted mid-SHOW → result=0, OFF.

Source files
------------

// File: rtl/mini_cpu_param.sv
// mini_cpu_param -- single-block multicycle CPU for the switch/pushbutton panel.
//
// Each instruction walks FETCH -> DECODE -> READ -> CALC -> STORE -> SHOW and
// returns to FETCH, one state per clock. The register file, ALU and
// button edge detection all live in this block.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      synchronous, active-high
//   opcode     instruction opcode switches
//   addr1      destination register (source for DISPLAY)
//   addr2      first source register
//   addr3_imm  shared field: top ADDR_W bits = addr3, whole field = immediate
//              (sign-magnitude, MSB is the sign)
//   ligar      power pushbutton, active-low
//   enviar     submit pushbutton, active-low
//   result     last shown value
//   on         high whenever the CPU is not OFF
//   estado     current state code
//   done       one-cycle pulse when an instruction completes
//
// Optional feature: define MINI_CPU_FLAGS_EN to add the zero/neg/ovf status
// outputs, updated together with result.
module mini_cpu_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int IMM_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [IMM_W-1:0]  addr3_imm,
    input  logic              ligar,
    input  logic              enviar,
    output logic [DATA_W-1:0] result,
    output logic              on,
    output logic [2:0]        estado,
    output logic              done
`ifdef MINI_CPU_FLAGS_EN
    ,
    output logic              zero,
    output logic              neg,
    output logic              ovf
`endif
);

    localparam int NREG  = 2**ADDR_W;
    localparam int MAG_W = IMM_W - 1;
    localparam int MSB   = DATA_W - 1;

    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_ADDI    = 3'd2;
    localparam logic [2:0] OP_SUB     = 3'd3;
    localparam logic [2:0] OP_SUBI    = 3'd4;
    localparam logic [2:0] OP_MUL     = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;
    localparam logic [2:0] OP_DISPLAY = 3'd7;

    typedef enum logic [2:0] {
        S_OFF    = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_READ   = 3'b011,
        S_CALC   = 3'b100,
        S_STORE  = 3'b110,
        S_SHOW   = 3'b111
    } state_t;

    state_t            state, state_n;
    logic              ligar_flag, enviar_flag;
    logic              ligar_rel, enviar_rel;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] a1_q, a2_q, a3;
    logic [IMM_W-1:0]  imm_q;
    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] opa, opb, alu_q, alu_n;
    logic [DATA_W-1:0] mag, immx, mul_lo;
`ifdef MINI_CPU_FLAGS_EN
    logic [2*DATA_W-1:0] prod;
    logic                ovf_q, ovf_n;
`endif

    assign estado = state;
    assign on     = (state != S_OFF);

    // A release event is a high button sample while its pressed flag is set.
    assign ligar_rel  = ligar & ligar_flag;
    assign enviar_rel = (state == S_FETCH) & enviar & enviar_flag;

    // addr3 shares the switches with the immediate and takes its top bits.
    assign a3   = imm_q[IMM_W-1 -: ADDR_W];
    assign mag  = {{(DATA_W-MAG_W){1'b0}}, imm_q[MAG_W-1:0]};
    assign immx = imm_q[IMM_W-1] ? ({DATA_W{1'b0}} - mag) : mag;

`ifdef MINI_CPU_FLAGS_EN
    // Sign-extended operands give the exact signed product in 2*DATA_W bits.
    assign prod   = {{DATA_W{opa[MSB]}}, opa} * {{DATA_W{opb[MSB]}}, opb};
    assign mul_lo = prod[DATA_W-1:0];
`else
    assign mul_lo = opa * opb;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_OFF;
        end else begin
            state <= state_n;
        end
    end

    // Next state; a ligar release overrides every other transition.
    always_comb begin
        state_n = state;
        case (state)
            S_OFF:    state_n = S_OFF;
            S_FETCH:  if (enviar_rel) state_n = S_DECODE;
            S_DECODE: state_n = S_READ;
            S_READ:   state_n = S_CALC;
            S_CALC:   state_n = S_STORE;
            S_STORE:  state_n = S_SHOW;
            S_SHOW:   state_n = S_FETCH;
            default:  state_n = S_OFF;
        endcase
        if (ligar_rel) begin
            state_n = (state == S_OFF) ? S_FETCH : S_OFF;
        end
    end

    // Button pressed flags; enviar is only armed while waiting in FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            ligar_flag  <= 1'b0;
            enviar_flag <= 1'b0;
        end else begin
            if (!ligar) begin
                ligar_flag <= 1'b1;
            end else if (ligar_flag) begin
                ligar_flag <= 1'b0;
            end
            if (state != S_FETCH) begin
                enviar_flag <= 1'b0;
            end else if (!enviar) begin
                enviar_flag <= 1'b1;
            end else if (enviar_flag) begin
                enviar_flag <= 1'b0;
            end
        end
    end

    // ALU result computed during CALC
    always_comb begin
        alu_n = '0;
        case (op_q)
            OP_LOAD:  alu_n = immx;
            OP_ADD:   alu_n = opa + opb;
            OP_ADDI:  alu_n = opa + immx;
            OP_SUB:   alu_n = opa - opb;
            OP_SUBI:  alu_n = opa - immx;
            OP_MUL:   alu_n = mul_lo;
            OP_CLEAR: alu_n = '0;
            default:  alu_n = regs[a1_q];
        endcase
    end

`ifdef MINI_CPU_FLAGS_EN
    // Signed overflow; for MUL the product overflows unless its upper half
    // plus the result sign bit are all copies of one bit.
    always_comb begin
        ovf_n = 1'b0;
        case (op_q)
            OP_ADD:  ovf_n = (opa[MSB] == opb[MSB])  && (alu_n[MSB] != opa[MSB]);
            OP_ADDI: ovf_n = (opa[MSB] == immx[MSB]) && (alu_n[MSB] != opa[MSB]);
            OP_SUB:  ovf_n = (opa[MSB] != opb[MSB])  && (alu_n[MSB] != opa[MSB]);
            OP_SUBI: ovf_n = (opa[MSB] != immx[MSB]) && (alu_n[MSB] != opa[MSB]);
            OP_MUL:  ovf_n = !((&prod[2*DATA_W-1:MSB]) || !(|prod[2*DATA_W-1:MSB]));
            default: ovf_n = 1'b0;
        endcase
    end
`endif

    // Datapath; a ligar release in any state aborts that state's work.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= '0;
            a1_q   <= '0;
            a2_q   <= '0;
            imm_q  <= '0;
            opa    <= '0;
            opb    <= '0;
            alu_q  <= '0;
            result <= '0;
            done   <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
`ifdef MINI_CPU_FLAGS_EN
            ovf_q <= 1'b0;
            zero  <= 1'b0;
            neg   <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (!ligar_rel) begin
                case (state)
                    S_FETCH: begin
                        if (enviar_rel) begin
                            op_q  <= opcode;
                            a1_q  <= addr1;
                            a2_q  <= addr2;
                            imm_q <= addr3_imm;
                        end
                    end
                    S_READ: begin
                        opa <= regs[a2_q];
                        opb <= regs[a3];
                    end
                    S_CALC: begin
                        alu_q <= alu_n;
`ifdef MINI_CPU_FLAGS_EN
                        ovf_q <= ovf_n;
`endif
                    end
                    S_STORE: begin
                        if (op_q == OP_CLEAR) begin
                            for (int i = 0; i < NREG; i++) regs[i] <= '0;
                            alu_q <= '0;
                        end else if (op_q != OP_DISPLAY) begin
                            regs[a1_q] <= alu_q;
                        end
                    end
                    S_SHOW: begin
                        result <= alu_q;
                        done   <= 1'b1;
`ifdef MINI_CPU_FLAGS_EN
                        zero <= (alu_q == '0);
                        neg  <= alu_q[MSB];
                        ovf  <= ovf_q;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mini_cpu_param.sv
// tb_mini_cpu_param -- self-checking bench for mini_cpu_param (default sizes).
// Expected results come from an arithmetic model of the instruction set and
// are queued when an instruction is submitted; a monitor pops one per done.
`timescale 1ns/1ps
module tb_mini_cpu_param;

    localparam logic [2:0] LOAD    = 3'd0;
    localparam logic [2:0] ADD     = 3'd1;
    localparam logic [2:0] ADDI    = 3'd2;
    localparam logic [2:0] SUB     = 3'd3;
    localparam logic [2:0] SUBI    = 3'd4;
    localparam logic [2:0] MUL     = 3'd5;
    localparam logic [2:0] CLEAR   = 3'd6;
    localparam logic [2:0] DISPLAY = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  opcode;
    logic [3:0]  addr1, addr2;
    logic [6:0]  addr3_imm;
    logic        ligar, enviar;
    logic [15:0] result;
    logic        on, done;
    logic [2:0]  estado;
`ifdef MINI_CPU_FLAGS_EN
    logic        zero, neg, ovf;
`endif

    mini_cpu_param dut (
        .clk(clk),
        .reset(reset),
        .opcode(opcode),
        .addr1(addr1),
        .addr2(addr2),
        .addr3_imm(addr3_imm),
        .ligar(ligar),
        .enviar(enviar),
        .result(result),
        .on(on),
        .estado(estado),
        .done(done)
`ifdef MINI_CPU_FLAGS_EN
        ,
        .zero(zero),
        .neg(neg),
        .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] res;
        bit          z;
        bit          n;
        bit          o;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] mreg [16];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] f3(input logic [3:0] a3);
        return {a3, 3'b000};
    endfunction

    function automatic int toSigned(input logic [15:0] v);
        return v[15] ? int'(v) - 65536 : int'(v);
    endfunction

    // Instruction-level reference model on plain integers.
    function automatic void modelExec(input logic [2:0] op, input logic [3:0] a1, input logic [3:0] a2,
                                      input logic [6:0] f, output logic [15:0] res,
                                      output bit z, output bit n, output bit o);
        logic [3:0] a3;
        int         immv, sa, sbv, full;
        longint     p;
        a3   = f[6:3];
        immv = int'(f[5:0]);
        if (f[6]) immv = -immv;
        sa   = toSigned(mreg[a2]);
        sbv  = toSigned(mreg[a3]);
        o    = 1'b0;
        full = 0;
        case (op)
            LOAD: full = immv;
            ADD:  full = sa + sbv;
            ADDI: full = sa + immv;
            SUB:  full = sa - sbv;
            SUBI: full = sa - immv;
            MUL: begin
                p    = longint'(sa) * longint'(sbv);
                full = int'(p);
                o    = (p > 32767) || (p < -32768);
            end
            CLEAR:   full = 0;
            default: full = int'(mreg[a1]);
        endcase
        if (op inside {ADD, ADDI, SUB, SUBI}) o = (full > 32767) || (full < -32768);
        res = full[15:0];
        if (op <= MUL) mreg[a1] = res;
        else if (op == CLEAR) for (int i = 0; i < 16; i++) mreg[i] = 16'd0;
        z = (res == 16'd0);
        n = res[15];
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'(done), 0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("result", 32'(result), 32'(mon_e.res));
                checkOutput("done_cycle", cyc, mon_e.cyc);
`ifdef MINI_CPU_FLAGS_EN
                checkOutput("flag_zero", 32'(zero), 32'(mon_e.z));
                checkOutput("flag_neg", 32'(neg), 32'(mon_e.n));
                checkOutput("flag_ovf", 32'(ovf), 32'(mon_e.o));
`endif
            end
        end
    end

    task automatic powerOn();
        ligar = 1'b0;
        repeat (2) @(negedge clk);
        ligar = 1'b1;
        @(negedge clk);
        checkOutput("power_estado", 32'(estado), 1);
        checkOutput("power_on", 32'(on), 1);
    endtask

    // Press and release enviar in FETCH; returns at the negedge in DECODE.
    task automatic sendInstr(input logic [2:0] op, input logic [3:0] a1, input logic [3:0] a2, input logic [6:0] f);
        opcode    = op;
        addr1     = a1;
        addr2     = a2;
        addr3_imm = f;
        enviar    = 1'b0;
        @(negedge clk);
        enviar = 1'b1;
        @(negedge clk);
        checkOutput("decode_after_release", 32'(estado), 2);
    endtask

    task automatic waitFetch();
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (estado == 3'b001) got = 1'b1;
            else @(negedge clk);
        end
        checkOutput("back_to_fetch", 32'(got), 1);
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [3:0] a1, input logic [3:0] a2,
                                 input logic [6:0] f, input bit noisy);
        exp_t e;
        sendInstr(op, a1, a2, f);
        modelExec(op, a1, a2, f, e.res, e.z, e.n, e.o);
        e.cyc = cyc + 5;
        sb.push_back(e);
        if (noisy) begin
            enviar = 1'b0;
            @(negedge clk);
            enviar = 1'b1;
        end
        waitFetch();
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit got;
        reset = 1'b1; ligar = 1'b1; enviar = 1'b1;
        opcode = '0; addr1 = '0; addr2 = '0; addr3_imm = '0;
        for (int i = 0; i < 16; i++) mreg[i] = 16'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_estado", 32'(estado), 0);
        checkOutput("reset_on", 32'(on), 0);
        checkOutput("reset_result", 32'(result), 0);
        checkOutput("reset_done", 32'(done), 0);
        @(negedge clk);
        powerOn();
        checkOutput("power_result", 32'(result), 0);
        checkOutput("power_done", 32'(done), 0);

        applyStimulus(LOAD, 4'd1, 4'd0, 7'b0000101, 1'b0);
        applyStimulus(DISPLAY, 4'd1, 4'd0, 7'd0, 1'b0);
        applyStimulus(LOAD, 4'd2, 4'd0, 7'h45, 1'b0);
        applyStimulus(ADD, 4'd3, 4'd1, f3(4'd2), 1'b0);
        applyStimulus(SUBI, 4'd4, 4'd3, 7'b0000011, 1'b0);
        checkOutput("subi_neg_result", 32'(result), 32'hFFFD);

        // Build 0x7FFF, then overflow it; then 0x100 squared.
        applyStimulus(LOAD, 4'd8, 4'd0, 7'h3F, 1'b0);
        applyStimulus(ADDI, 4'd8, 4'd8, 7'd1, 1'b0);
        applyStimulus(MUL, 4'd9, 4'd8, f3(4'd8), 1'b0);
        repeat (3) applyStimulus(ADD, 4'd9, 4'd9, f3(4'd9), 1'b0);
        applyStimulus(SUBI, 4'd5, 4'd9, 7'd1, 1'b0);
        applyStimulus(ADD, 4'd6, 4'd5, f3(4'd5), 1'b0);
        checkOutput("add_ovf_result", 32'(result), 32'hFFFE);
        applyStimulus(LOAD, 4'd11, 4'd0, 7'd4, 1'b0);
        applyStimulus(MUL, 4'd10, 4'd8, f3(4'd11), 1'b0);
        applyStimulus(MUL, 4'd12, 4'd10, f3(4'd10), 1'b0);
        checkOutput("mul_wrap_result", 32'(result), 0);

        // Power off while in CALC: instruction must be discarded.
        sendInstr(ADDI, 4'd1, 4'd1, 7'd10);
        @(negedge clk);
        checkOutput("abort_read", 32'(estado), 3);
        ligar = 1'b0;
        @(negedge clk);
        checkOutput("abort_calc", 32'(estado), 4);
        ligar = 1'b1;
        @(negedge clk);
        checkOutput("abort_off", 32'(estado), 0);
        checkOutput("abort_on", 32'(on), 0);
        repeat (8) @(negedge clk);
        checkOutput("abort_stays_off", 32'(estado), 0);
        powerOn();
        applyStimulus(DISPLAY, 4'd1, 4'd0, 7'd0, 1'b0);

        // enviar activity during execution must not start another instruction.
        applyStimulus(ADD, 4'd7, 4'd1, f3(4'd1), 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("noise_ignored", 32'(estado), 1);

        // ligar and enviar released together in FETCH: power off wins.
        enviar = 1'b0; ligar = 1'b0;
        @(negedge clk);
        enviar = 1'b1; ligar = 1'b1;
        @(negedge clk);
        checkOutput("both_release_off", 32'(estado), 0);
        repeat (8) @(negedge clk);
        checkOutput("both_release_stays_off", 32'(estado), 0);
        powerOn();
        applyStimulus(DISPLAY, 4'd7, 4'd0, 7'd0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            applyStimulus(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          7'($urandom_range(0, 127)), bit'($urandom_range(0, 1)));
        end

        applyStimulus(CLEAR, 4'd0, 4'd0, 7'd0, 1'b0);
        applyStimulus(DISPLAY, 4'd1, 4'd0, 7'd0, 1'b0);
        applyStimulus(LOAD, 4'd1, 4'd0, 7'd9, 1'b0);

        // Synchronous reset in the middle of SHOW.
        sendInstr(DISPLAY, 4'd1, 4'd0, 7'd0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (estado == 3'b111) got = 1'b1;
            else @(negedge clk);
        end
        checkOutput("reach_show", 32'(got), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) mreg[i] = 16'd0;
        checkOutput("midshow_result", 32'(result), 0);
        checkOutput("midshow_estado", 32'(estado), 0);
        checkOutput("midshow_done", 32'(done), 0);
        @(negedge clk);
        powerOn();
        applyStimulus(DISPLAY, 4'd1, 4'd0, 7'd0, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
